// File: rtl/mul_div_unit_pkg.sv
// Shared op codes and FSM state encoding for the iterative multiply/divide unit.
// The control unit imports the op codes from here as well.
package mul_div_unit_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative WIDTH-bit multiply/divide: one bit per cycle on magnitudes, signs fixed up afterwards.
// Produces HI/LO for write-back; start/busy/done handshake with one op in flight.
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CNT_W = $clog2(WIDTH);

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
      return ~v + WIDTH'(1);
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
      return ~v + (2*WIDTH)'(1);
   endfunction

   state_e                  state, state_nxt;
   logic                    load, calc_en, fix_en;
   logic [CNT_W-1:0]        cnt;

   op_e                     op_in;
   logic                    is_signed_op, is_div_op, s1_neg, s2_neg;
   logic signed [WIDTH-1:0] src1_s, src2_s;
   logic [WIDTH-1:0]        mag1, mag2;

   logic                    is_div_q, neg_res_q, neg_rem_q, zero_div_q;
   logic [WIDTH-1:0]        opnd_q, src1_raw_q;
   logic [WIDTH-1:0]        acc_hi, acc_lo, acc_hi_nxt, acc_lo_nxt;

   logic [WIDTH:0]          mul_sum, div_shift;
   logic [WIDTH-1:0]        div_diff;
   logic                    div_ge;

   logic [2*WIDTH-1:0]      prod_fix;
   logic [WIDTH-1:0]        hi_fix, lo_fix;

   // Operand decode at the start handshake
   assign op_in        = op_e'(op_i);
   assign is_signed_op = (op_in == OP_MULT) || (op_in == OP_DIV);
   assign is_div_op    = (op_in == OP_DIV)  || (op_in == OP_DIVU);
   assign src1_s       = src1_i;
   assign src2_s       = src2_i;
   assign s1_neg       = is_signed_op && (src1_s < 0);
   assign s2_neg       = is_signed_op && (src2_s < 0);
   assign mag1         = s1_neg ? neg_w(src1_i) : src1_i;
   assign mag2         = s2_neg ? neg_w(src2_i) : src2_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (load)
            cnt <= CNT_W'(WIDTH - 1);
         else if (calc_en && (cnt != '0))
            cnt <= cnt - CNT_W'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start_i) state_nxt = CALC;
         CALC:    if (cnt == '0) state_nxt = FIX;
         FIX:     state_nxt = DONE;
         DONE:    state_nxt = start_i ? CALC : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      load    = ((state == IDLE) || (state == DONE)) && start_i;
      calc_en = (state == CALC);
      fix_en  = (state == FIX);
      busy_o  = (state == CALC) || (state == FIX);
      done_o  = (state == DONE);
   end

   // MUL: multiplier sits in acc_lo and shifts out as the product shifts in.
   // DIV: dividend sits in acc_lo, quotient bits shift in; acc_hi is the partial remainder.
   always_comb begin
      mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : '0);
      div_shift  = {acc_hi, acc_lo[WIDTH-1]};
      div_ge     = (div_shift >= {1'b0, opnd_q});
      div_diff   = div_shift[WIDTH-1:0] - opnd_q;
      acc_hi_nxt = mul_sum[WIDTH:1];
      acc_lo_nxt = {mul_sum[0], acc_lo[WIDTH-1:1]};
      if (is_div_q) begin
         acc_hi_nxt = div_ge ? div_diff : div_shift[WIDTH-1:0];
         acc_lo_nxt = {acc_lo[WIDTH-2:0], div_ge};
      end
   end

   always_ff @(posedge clk_i) begin
      if (load) begin
         is_div_q   <= is_div_op;
         neg_res_q  <= s1_neg ^ s2_neg;
         neg_rem_q  <= s1_neg;
         zero_div_q <= (src2_i == '0);
         src1_raw_q <= src1_i;
         acc_hi     <= '0;
         opnd_q     <= is_div_op ? mag2 : mag1;
         acc_lo     <= is_div_op ? mag1 : mag2;
      end else if (calc_en) begin
         acc_hi <= acc_hi_nxt;
         acc_lo <= acc_lo_nxt;
      end
   end

   // Sign fix-up; a zero divisor bypasses it and returns the raw dividend
   always_comb begin
      prod_fix = neg_res_q ? neg_2w({acc_hi, acc_lo}) : {acc_hi, acc_lo};
      hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
      lo_fix   = prod_fix[WIDTH-1:0];
      if (is_div_q) begin
         if (zero_div_q) begin
            hi_fix = src1_raw_q;
            lo_fix = '1;
         end else begin
            hi_fix = neg_rem_q ? neg_w(acc_hi) : acc_hi;
            lo_fix = neg_res_q ? neg_w(acc_lo) : acc_lo;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hi_o <= '0;
         lo_o <= '0;
      end else if (fix_en) begin
         hi_o <= hi_fix;
         lo_o <= lo_fix;
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed corner cases plus random ops against a 64-bit arithmetic model.
module tb_mul_div_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] src1, src2;
   logic         busy, done;
   logic [W-1:0] hi, lo;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mul_div_unit #(.WIDTH(W)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (start),
      .op_i    (op),
      .src1_i  (src1),
      .src2_i  (src2),
      .busy_o  (busy),
      .done_o  (done),
      .hi_o    (hi),
      .lo_o    (lo)
   );

   function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] eh, output logic [31:0] el);
      longint          sa, sb, sq, sr;
      longint unsigned up;
      logic [63:0]     r64;
      sa = $signed(a);
      sb = $signed(b);
      r64 = '0;
      case (o)
         2'd0: r64 = sa * sb;
         2'd1: begin up = {32'd0, a} * {32'd0, b}; r64 = up; end
         2'd2: if (b == 0) r64 = {a, 32'hFFFF_FFFF};
               else begin sq = sa / sb; sr = sa % sb; r64 = {sr[31:0], sq[31:0]}; end
         default: if (b == 0) r64 = {a, 32'hFFFF_FFFF};
                  else r64 = {a % b, a / b};
      endcase
      eh = r64[63:32];
      el = r64[31:0];
   endfunction

   // Start sampled at the posedge inside this task; returns 1 time unit after it
   task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; op = o; src1 = a; src2 = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = 2'($urandom_range(0, 3));
      src1  = $urandom;
      src2  = $urandom;
   endtask

   task automatic wait_done(output int n, output int nbusy);
      n = 0; nbusy = 0;
      while (!done && n < 100) begin
         if (busy) nbusy++;
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; op = 2'd0; src1 = '0; src2 = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (hi !== '0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
      checks++; if (lo !== '0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [1:0]  ops [8] = '{2'd1, 2'd0, 2'd0, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2};
      logic [31:0] as  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFF9,
                               32'd100, 32'h8000_0000, 32'd5, 32'hFFFF_FFFB};
      logic [31:0] bs  [8] = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd2,
                               32'd7, 32'hFFFF_FFFF, 32'd0, 32'd0};
      logic [31:0] ehs [8] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h4000_0000, 32'hFFFF_FFFF,
                               32'd2, 32'd0, 32'd5, 32'hFFFF_FFFB};
      logic [31:0] els [8] = '{32'h0000_0001, 32'hFFFF_FFEB, 32'h0, 32'hFFFF_FFFD,
                               32'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      int n, nb;
      for (int i = 0; i < 8; i++) begin
         start_op(ops[i], as[i], bs[i]);
         wait_done(n, nb);
         checks++; if (n !== 33) begin errors++; $display("FAIL dir%0d_latency: got %0d expected 33", i, n); end
         checks++; if (nb !== 33) begin errors++; $display("FAIL dir%0d_busy_cycles: got %0d expected 33", i, nb); end
         checks++; if (hi !== ehs[i]) begin errors++; $display("FAIL dir%0d_hi: got %h expected %h", i, hi, ehs[i]); end
         checks++; if (lo !== els[i]) begin errors++; $display("FAIL dir%0d_lo: got %h expected %h", i, lo, els[i]); end
      end
   endtask

   task automatic test_random();
      logic [1:0]  o;
      logic [31:0] a, b, eh, el;
      int n, nb;
      for (int i = 0; i < 40; i++) begin
         o = 2'($urandom_range(0, 3));
         a = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 1000);
         case ($urandom_range(0, 5))
            0:       b = 32'd0;
            1, 2:    b = $urandom_range(1, 20);
            3:       b = 32'd0 - $urandom_range(1, 20);
            default: b = $urandom;
         endcase
         model(o, a, b, eh, el);
         start_op(o, a, b);
         wait_done(n, nb);
         checks++; if (n !== 33) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected 33", i, n); end
         checks++; if (hi !== eh) begin errors++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h: got %h expected %h", i, o, a, b, hi, eh); end
         checks++; if (lo !== el) begin errors++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h: got %h expected %h", i, o, a, b, lo, el); end
      end
   endtask

   task automatic test_ignore_midcalc();
      logic [31:0] eh, el;
      int n, m, nb;
      model(2'd3, 32'd1234567, 32'd89, eh, el);
      start_op(2'd3, 32'd1234567, 32'd89);
      n = 0;
      repeat (10) begin @(posedge clk); #1; n++; end
      start = 1'b1; op = 2'd0; src1 = 32'hDEAD_BEEF; src2 = 32'h1234_5678;
      @(posedge clk); #1; n++;
      start = 1'b0;
      wait_done(m, nb);
      checks++; if (n + m !== 33) begin errors++; $display("FAIL midcalc_latency: got %0d expected 33", n + m); end
      checks++; if (hi !== eh) begin errors++; $display("FAIL midcalc_hi: got %h expected %h", hi, eh); end
      checks++; if (lo !== el) begin errors++; $display("FAIL midcalc_lo: got %h expected %h", lo, el); end
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midcalc_no_requeue: busy got %b expected 0", busy); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a1, b1, a2, b2, eh1, el1, eh2, el2;
      int n, nb;
      a1 = $urandom; b1 = $urandom;
      a2 = $urandom; b2 = $urandom_range(3, 1000);
      model(2'd0, a1, b1, eh1, el1);
      model(2'd2, a2, b2, eh2, el2);
      start_op(2'd0, a1, b1);
      wait_done(n, nb);
      checks++; if (hi !== eh1) begin errors++; $display("FAIL b2b_first_hi: got %h expected %h", hi, eh1); end
      checks++; if (lo !== el1) begin errors++; $display("FAIL b2b_first_lo: got %h expected %h", lo, el1); end
      start_op(2'd2, a2, b2);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_no_gap: busy got %b expected 1", busy); end
      checks++; if (hi !== eh1) begin errors++; $display("FAIL b2b_hold_hi: got %h expected %h", hi, eh1); end
      wait_done(n, nb);
      checks++; if (n !== 33) begin errors++; $display("FAIL b2b_latency: got %0d expected 33", n); end
      checks++; if (hi !== eh2) begin errors++; $display("FAIL b2b_second_hi: got %h expected %h", hi, eh2); end
      checks++; if (lo !== el2) begin errors++; $display("FAIL b2b_second_lo: got %h expected %h", lo, el2); end
      repeat (5) @(posedge clk);
      #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL hold_done: got %b expected 0", done); end
      checks++; if (lo !== el2) begin errors++; $display("FAIL hold_lo: got %h expected %h", lo, el2); end
   endtask

   task automatic test_reset_mid();
      int n, nb;
      start_op(2'd2, 32'hFFFF_FF9C, 32'd7);
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
      checks++; if (hi !== '0) begin errors++; $display("FAIL midrst_hi: got %h expected 0", hi); end
      checks++; if (lo !== '0) begin errors++; $display("FAIL midrst_lo: got %h expected 0", lo); end
      @(negedge clk);
      rst = 1'b0;
      start_op(2'd1, 32'd6, 32'd7);
      wait_done(n, nb);
      checks++; if (n !== 33) begin errors++; $display("FAIL postrst_latency: got %0d expected 33", n); end
      checks++; if (lo !== 32'd42) begin errors++; $display("FAIL postrst_lo: got %h expected 0000002a", lo); end
      checks++; if (hi !== 32'd0) begin errors++; $display("FAIL postrst_hi: got %h expected 0", hi); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_ignore_midcalc();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
